axi_mem_arb: RTL and testbench
==============================

Name: axi_mem_arb

Overview:
- Round-robin arbiter sharing one single-outstanding AXI4 memory slave (the simulation DDR/code memory model) between NUM_MST requesters, e.g. core I-cache, D-cache and DMA.
- Read (AR/R) and write (AW/W/B) paths are arbitrated independently, one transaction per path at a time.
- The grant is held for the whole burst and its response.
- Sits in the testbench/SoC interconnect directly in front of the memory model.

Parameters:
- NUM_MST, 2, number of requesters (2..8).
- ADDR_WTH, 32, address width.
- DATA_WTH, 256, data width.
- ID_WIDTH, 4, AXI ID width; passed through unchanged.
- TIMEOUT, 1024, cycles without a handshake in a data/response phase before err_o asserts.

Ports:
- clk_i in 1 clock.
- rst_i in 1 synchronous active-high reset.
- req_aw{addr,len,size,burst,id} in NUM_MST*{ADDR_WTH,8,3,2,ID_WIDTH} packed per-requester AW fields, requester k at slice k.
- req_awvalid in NUM_MST; req_awready out NUM_MST.
- req_w{data,strb,last,valid} in NUM_MST*{DATA_WTH,DATA_WTH/8,1,1}; req_wready out NUM_MST.
- req_b{resp,id,valid} out {2,ID_WIDTH,NUM_MST}, shared resp/id; req_bready in NUM_MST.
- req_ar{addr,len,size,burst,id} in as AW; req_arvalid in NUM_MST; req_arready out NUM_MST.
- req_r{data,resp,last,id,valid} out {DATA_WTH,2,1,ID_WIDTH,NUM_MST}, shared data/resp/last/id; req_rready in NUM_MST.
- mem_aw{addr,len,size,burst,id,valid} out; mem_awready in.
- mem_w{data,strb,last,valid} out; mem_wready in.
- mem_b{resp,id,valid} in; mem_bready out.
- mem_ar{addr,len,size,burst,id,valid} out; mem_arready in.
- mem_r{data,resp,last,id,valid} in; mem_rready out.
- wr_gnt_o out NUM_MST one-hot current write owner, 0 when idle.
- rd_gnt_o out NUM_MST one-hot current read owner, 0 when idle.
- err_o out 1 sticky timeout flag.

Behaviour:
- Reset: write FSM=W_IDLE, read FSM=R_IDLE, grants 0, both RR pointers = NUM_MST-1 (requester 0 wins first), err_o=0, timeout counters 0.
- All mem_*valid/ready and req_*valid/ready outputs are 0 in reset and whenever ungranted.
- Write FSM:
  - W_IDLE: if any req_awvalid, register one-hot winner = first set bit scanning from ptr+1 modulo NUM_MST. Go to W_ADDR.
  - W_ADDR: mem_aw* = winner's fields, mem_awvalid=1, winner's req_awready=mem_awready. On handshake go to W_DATA.
  - W_DATA: W channel routed combinationally from winner. On mem_wvalid&mem_wready&mem_wlast go to W_RESP.
  - W_RESP: mem_b* routed to winner only; mem_bready=winner's req_bready. On handshake: ptr=winner, grant cleared, go to W_IDLE.
- Read FSM:
  - R_IDLE / R_ADDR: same as write.
  - R_DATA: R routed to winner. On mem_rvalid&mem_rready&mem_rlast: ptr=winner, go to R_IDLE.
- Latency: one arbitration cycle. AWVALID presented in cycle t produces mem_awvalid in t+1. Zero added latency on W/B/R beats.
- A requester's AWVALID is never acknowledged while it is not the write owner. Non-owner W beats are held off (wready=0).
- Simultaneous requests: the lowest index after ptr wins. Requester k asserting continuously is served at most once per NUM_MST grants while others wait.
- Read and write may be owned by different or the same requester concurrently.
- A new grant is issued only in IDLE. The cycle after a burst completes is always IDLE, giving a 1-cycle bubble.
- Timeout: a per-FSM counter, cleared on any handshake on that path and in IDLE, increments otherwise in ADDR/DATA/RESP. When it reaches TIMEOUT, err_o=1 (sticky until reset). The FSM state is unchanged.
- rst_i mid-burst: FSMs return to IDLE next edge and all valids drop. No completion is generated.
- ID, len, size and burst are passed unmodified; the arbiter does not check 4 KiB crossing.

Test Plan:
- Single write, requester 1, awaddr=0x80001000, awlen=3: mem_awvalid one cycle after req_awvalid; 4 W beats forwarded; req_bvalid[1]=1 only; wr_gnt_o=0b10 until B handshake, then 0.
- Requesters 0 and 1 both assert arvalid at reset exit with arlen=0: order 0,1,0,1 over four back-to-back requests; rd_gnt_o alternates; 1-cycle idle between bursts.
- Concurrent: requester 0 writes awlen=7 while requester 1 reads arlen=7 at 0x9a200000: both complete with no stall from cross-path interference; rid/bid equal the issued IDs.
- Requester 1 drives wvalid before its grant while requester 0 owns write: req_wready[1]=0, mem_wdata carries only requester 0 data until its wlast.
- Memory holds mem_bvalid=0 for TIMEOUT=16 cycles: err_o rises on cycle 16 and stays 1 after the late B completes.
- rst_i pulsed during beat 2 of an 8-beat read: next cycle rd_gnt_o=0, mem_arvalid=0, req_rvalid=0; a fresh request afterwards is granted to requester 0.

Source files
------------

// File: rtl/axi_mem_arb.sv
// axi_mem_arb: round-robin arbiter sharing one single-outstanding AXI4 memory slave between NUM_MST requesters,
// with independent read and write arbitration and a sticky data/response-phase timeout flag.
module axi_mem_arb #(
  parameter int NUM_MST  = 2,
  parameter int ADDR_WTH = 32,
  parameter int DATA_WTH = 256,
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MST*ADDR_WTH-1:0]      req_awaddr,
  input  logic [NUM_MST*8-1:0]             req_awlen,
  input  logic [NUM_MST*3-1:0]             req_awsize,
  input  logic [NUM_MST*2-1:0]             req_awburst,
  input  logic [NUM_MST*ID_WIDTH-1:0]      req_awid,
  input  logic [NUM_MST-1:0]               req_awvalid,
  output logic [NUM_MST-1:0]               req_awready,
  input  logic [NUM_MST*DATA_WTH-1:0]      req_wdata,
  input  logic [NUM_MST*DATA_WTH/8-1:0]    req_wstrb,
  input  logic [NUM_MST-1:0]               req_wlast,
  input  logic [NUM_MST-1:0]               req_wvalid,
  output logic [NUM_MST-1:0]               req_wready,
  output logic [1:0]                       req_bresp,
  output logic [ID_WIDTH-1:0]              req_bid,
  output logic [NUM_MST-1:0]               req_bvalid,
  input  logic [NUM_MST-1:0]               req_bready,
  input  logic [NUM_MST*ADDR_WTH-1:0]      req_araddr,
  input  logic [NUM_MST*8-1:0]             req_arlen,
  input  logic [NUM_MST*3-1:0]             req_arsize,
  input  logic [NUM_MST*2-1:0]             req_arburst,
  input  logic [NUM_MST*ID_WIDTH-1:0]      req_arid,
  input  logic [NUM_MST-1:0]               req_arvalid,
  output logic [NUM_MST-1:0]               req_arready,
  output logic [DATA_WTH-1:0]              req_rdata,
  output logic [1:0]                       req_rresp,
  output logic                             req_rlast,
  output logic [ID_WIDTH-1:0]              req_rid,
  output logic [NUM_MST-1:0]               req_rvalid,
  input  logic [NUM_MST-1:0]               req_rready,
  output logic [ADDR_WTH-1:0]              mem_awaddr,
  output logic [7:0]                       mem_awlen,
  output logic [2:0]                       mem_awsize,
  output logic [1:0]                       mem_awburst,
  output logic [ID_WIDTH-1:0]              mem_awid,
  output logic                             mem_awvalid,
  input  logic                             mem_awready,
  output logic [DATA_WTH-1:0]              mem_wdata,
  output logic [DATA_WTH/8-1:0]            mem_wstrb,
  output logic                             mem_wlast,
  output logic                             mem_wvalid,
  input  logic                             mem_wready,
  input  logic [1:0]                       mem_bresp,
  input  logic [ID_WIDTH-1:0]              mem_bid,
  input  logic                             mem_bvalid,
  output logic                             mem_bready,
  output logic [ADDR_WTH-1:0]              mem_araddr,
  output logic [7:0]                       mem_arlen,
  output logic [2:0]                       mem_arsize,
  output logic [1:0]                       mem_arburst,
  output logic [ID_WIDTH-1:0]              mem_arid,
  output logic                             mem_arvalid,
  input  logic                             mem_arready,
  input  logic [DATA_WTH-1:0]              mem_rdata,
  input  logic [1:0]                       mem_rresp,
  input  logic                             mem_rlast,
  input  logic [ID_WIDTH-1:0]              mem_rid,
  input  logic                             mem_rvalid,
  output logic                             mem_rready,
  output logic [NUM_MST-1:0]               wr_gnt_o,
  output logic [NUM_MST-1:0]               rd_gnt_o,
  output logic                             err_o
);
  localparam int IW = $clog2(NUM_MST);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = DATA_WTH / 8;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [IW-1:0] w_idx_q, w_idx_d, w_ptr_q, w_ptr_d, w_win;
  logic [IW-1:0] r_idx_q, r_idx_d, r_ptr_q, r_ptr_d, r_win;
  logic [CW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic err_q, err_d, w_any, r_any;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  // Returns {found, index}; scanning offsets high to low leaves the lowest offset after p as winner.
  function automatic logic [IW:0] rr_pick(input logic [NUM_MST-1:0] v, input logic [IW-1:0] p);
    logic [IW:0] res;
    res = '0;
    for (int i = NUM_MST; i >= 1; i--) begin
      int k;
      k = (int'(p) + i) % NUM_MST;
      if (v[k]) res = {1'b1, IW'(k)};
    end
    return res;
  endfunction
  assign {w_any, w_win} = rr_pick(req_awvalid, w_ptr_q);
  assign {r_any, r_win} = rr_pick(req_arvalid, r_ptr_q);
  assign wr_gnt_o = (w_state_q == W_IDLE) ? '0 : NUM_MST'(1) << w_idx_q;
  assign rd_gnt_o = (r_state_q == R_IDLE) ? '0 : NUM_MST'(1) << r_idx_q;
  assign err_o = err_q;
  assign mem_awaddr  = req_awaddr[w_idx_q*ADDR_WTH +: ADDR_WTH];
  assign mem_awlen   = req_awlen[w_idx_q*8 +: 8];
  assign mem_awsize  = req_awsize[w_idx_q*3 +: 3];
  assign mem_awburst = req_awburst[w_idx_q*2 +: 2];
  assign mem_awid    = req_awid[w_idx_q*ID_WIDTH +: ID_WIDTH];
  assign mem_awvalid = w_state_q == W_ADDR;
  assign aw_hs       = mem_awvalid & mem_awready;
  assign req_awready = aw_hs ? wr_gnt_o : '0;
  assign mem_wdata   = req_wdata[w_idx_q*DATA_WTH +: DATA_WTH];
  assign mem_wstrb   = req_wstrb[w_idx_q*SW +: SW];
  assign mem_wlast   = req_wlast[w_idx_q];
  assign mem_wvalid  = (w_state_q == W_DATA) & req_wvalid[w_idx_q];
  assign w_hs        = mem_wvalid & mem_wready;
  assign req_wready  = (w_state_q == W_DATA && mem_wready) ? wr_gnt_o : '0;
  assign mem_bready  = (w_state_q == W_RESP) & req_bready[w_idx_q];
  assign b_hs        = mem_bready & mem_bvalid;
  assign req_bvalid  = (w_state_q == W_RESP && mem_bvalid) ? wr_gnt_o : '0;
  assign req_bresp   = mem_bresp;
  assign req_bid     = mem_bid;
  assign mem_araddr  = req_araddr[r_idx_q*ADDR_WTH +: ADDR_WTH];
  assign mem_arlen   = req_arlen[r_idx_q*8 +: 8];
  assign mem_arsize  = req_arsize[r_idx_q*3 +: 3];
  assign mem_arburst = req_arburst[r_idx_q*2 +: 2];
  assign mem_arid    = req_arid[r_idx_q*ID_WIDTH +: ID_WIDTH];
  assign mem_arvalid = r_state_q == R_ADDR;
  assign ar_hs       = mem_arvalid & mem_arready;
  assign req_arready = ar_hs ? rd_gnt_o : '0;
  assign mem_rready  = (r_state_q == R_DATA) & req_rready[r_idx_q];
  assign r_hs        = mem_rready & mem_rvalid;
  assign req_rvalid  = (r_state_q == R_DATA && mem_rvalid) ? rd_gnt_o : '0;
  assign req_rdata   = mem_rdata;
  assign req_rresp   = mem_rresp;
  assign req_rlast   = mem_rlast;
  assign req_rid     = mem_rid;
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_ptr_d   = w_ptr_q;
    case (w_state_q)
      W_IDLE: if (w_any) begin w_state_d = W_ADDR; w_idx_d = w_win; end
      W_ADDR: if (aw_hs) w_state_d = W_DATA;
      W_DATA: if (w_hs && mem_wlast) w_state_d = W_RESP;
      W_RESP: if (b_hs) begin w_state_d = W_IDLE; w_ptr_d = w_idx_q; end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_ptr_d   = r_ptr_q;
    case (r_state_q)
      R_IDLE: if (r_any) begin r_state_d = R_ADDR; r_idx_d = r_win; end
      R_ADDR: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (r_hs && mem_rlast) begin r_state_d = R_IDLE; r_ptr_d = r_idx_q; end
      default: r_state_d = R_IDLE;
    endcase
  end
  // Counters saturate at TIMEOUT so the flag condition cannot wrap away.
  always_comb begin
    w_cnt_d = (w_state_q == W_IDLE || aw_hs || w_hs || b_hs) ? '0 :
              (w_cnt_q == CW'(TIMEOUT)) ? w_cnt_q : w_cnt_q + 1'b1;
    r_cnt_d = (r_state_q == R_IDLE || ar_hs || r_hs) ? '0 :
              (r_cnt_q == CW'(TIMEOUT)) ? r_cnt_q : r_cnt_q + 1'b1;
    err_d   = err_q | (w_cnt_d == CW'(TIMEOUT)) | (r_cnt_d == CW'(TIMEOUT));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_idx_q   <= '0;
      r_idx_q   <= '0;
      w_ptr_q   <= IW'(NUM_MST - 1);
      r_ptr_q   <= IW'(NUM_MST - 1);
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_idx_q   <= w_idx_d;
      r_idx_q   <= r_idx_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_mem_arb.sv
// tb_axi_mem_arb: directed-vector bench for axi_mem_arb with two requesters; the bench plays both the
// requesters and the memory slave and checks routing, round-robin order, timeout and reset behaviour.
module tb_axi_mem_arb;
  localparam int N = 2, AW = 32, DW = 32, IDW = 4, TO = 16;
  logic clk, rst;
  logic [N*AW-1:0] req_awaddr, req_araddr;
  logic [N*8-1:0] req_awlen, req_arlen;
  logic [N*3-1:0] req_awsize, req_arsize;
  logic [N*2-1:0] req_awburst, req_arburst;
  logic [N*IDW-1:0] req_awid, req_arid;
  logic [N-1:0] req_awvalid, req_awready, req_wlast, req_wvalid, req_wready, req_bvalid, req_bready;
  logic [N-1:0] req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*DW-1:0] req_wdata;
  logic [N*DW/8-1:0] req_wstrb;
  logic [1:0] req_bresp, req_rresp, mem_bresp, mem_rresp, mem_awburst, mem_arburst;
  logic [IDW-1:0] req_bid, req_rid, mem_awid, mem_bid, mem_arid, mem_rid;
  logic [DW-1:0] req_rdata, mem_wdata, mem_rdata;
  logic req_rlast, mem_rlast, mem_wlast;
  logic [AW-1:0] mem_awaddr, mem_araddr;
  logic [7:0] mem_awlen, mem_arlen;
  logic [2:0] mem_awsize, mem_arsize;
  logic [DW/8-1:0] mem_wstrb;
  logic mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
  logic mem_arvalid, mem_arready, mem_rvalid, mem_rready, err_o;
  logic [N-1:0] wr_gnt_o, rd_gnt_o;
  int n_vec = 0, n_err = 0;
  axi_mem_arb #(.NUM_MST(N), .ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IDW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awsize(req_awsize), .req_awburst(req_awburst),
    .req_awid(req_awid), .req_awvalid(req_awvalid), .req_awready(req_awready),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wlast(req_wlast), .req_wvalid(req_wvalid),
    .req_wready(req_wready), .req_bresp(req_bresp), .req_bid(req_bid), .req_bvalid(req_bvalid),
    .req_bready(req_bready),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_arid(req_arid), .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast), .req_rid(req_rid),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
    .mem_awid(mem_awid), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_bresp(mem_bresp), .mem_bid(mem_bid), .mem_bvalid(mem_bvalid),
    .mem_bready(mem_bready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arid(mem_arid), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rid(mem_rid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .wr_gnt_o(wr_gnt_o), .rd_gnt_o(rd_gnt_o), .err_o(err_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {req_awaddr, req_awlen, req_awsize, req_awburst, req_awid, req_awvalid} = '0;
    {req_araddr, req_arlen, req_arsize, req_arburst, req_arid, req_arvalid} = '0;
    {req_wdata, req_wstrb, req_wlast, req_wvalid, req_bready, req_rready} = '0;
    {mem_bresp, mem_bid, mem_bvalid, mem_rdata, mem_rresp, mem_rlast, mem_rid, mem_rvalid} = '0;
    mem_awready = 1'b1; mem_wready = 1'b1; mem_arready = 1'b1;
    cyc(2);
    chk("rst_wr_gnt", 64'(wr_gnt_o), 0);
    chk("rst_rd_gnt", 64'(rd_gnt_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_valids", 64'({mem_awvalid, mem_arvalid, mem_wvalid, mem_bready, mem_rready}), 0);
    rst = 1'b0;
    // single write from requester 1, 4 beats
    req_awaddr[AW +: AW] = 32'h8000_1000; req_awlen[8 +: 8] = 8'd3; req_awid[IDW +: IDW] = 4'd5;
    req_awvalid = 2'b10;
    #1 chk("w1_no_aw_yet", 64'(mem_awvalid), 0);
    cyc();
    chk("w1_awvalid", 64'(mem_awvalid), 1);
    chk("w1_awaddr", 64'(mem_awaddr), 64'h8000_1000);
    chk("w1_awlen", 64'(mem_awlen), 3);
    chk("w1_awid", 64'(mem_awid), 5);
    chk("w1_gnt", 64'(wr_gnt_o), 2'b10);
    chk("w1_awready", 64'(req_awready), 2'b10);
    cyc();
    req_awvalid = '0;
    for (int i = 0; i < 4; i++) begin
      req_wdata[DW +: DW] = 32'hD0 + i; req_wlast = (i == 3) ? 2'b10 : 2'b00; req_wvalid = 2'b10;
      #1;
      chk("w1_wvalid", 64'(mem_wvalid), 1);
      chk("w1_wdata", 64'(mem_wdata), 64'hD0 + i);
      chk("w1_wready", 64'(req_wready), 2'b10);
      cyc();
    end
    req_wvalid = '0; req_wlast = '0;
    mem_bvalid = 1'b1; mem_bid = 4'd5; req_bready = 2'b10;
    #1;
    chk("w1_bvalid", 64'(req_bvalid), 2'b10);
    chk("w1_bid", 64'(req_bid), 5);
    chk("w1_bready", 64'(mem_bready), 1);
    chk("w1_gnt_resp", 64'(wr_gnt_o), 2'b10);
    cyc();
    mem_bvalid = 1'b0; req_bready = '0;
    chk("w1_gnt_done", 64'(wr_gnt_o), 0);
    // round-robin reads, both requesters continuously asking, single-beat bursts
    req_arid = {4'd2, 4'd1}; req_arvalid = 2'b11; req_rready = 2'b11;
    mem_rvalid = 1'b1; mem_rlast = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1 chk("rr_bubble", 64'(rd_gnt_o), 0);
      cyc();
      chk("rr_gnt", 64'(rd_gnt_o), (g % 2) ? 2'b10 : 2'b01);
      chk("rr_arvalid", 64'(mem_arvalid), 1);
      chk("rr_arid", 64'(mem_arid), (g % 2) ? 2 : 1);
      cyc();
      mem_rid = (g % 2) ? 4'd2 : 4'd1;
      #1;
      chk("rr_rvalid", 64'(req_rvalid), (g % 2) ? 2'b10 : 2'b01);
      chk("rr_rid", 64'(req_rid), (g % 2) ? 2 : 1);
      cyc();
    end
    req_arvalid = '0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    // concurrent write by 0 and read by 1, 8 beats each
    req_awlen[0 +: 8] = 8'd7; req_awid[0 +: IDW] = 4'd3; req_awvalid = 2'b01;
    req_araddr[AW +: AW] = 32'h9a20_0000; req_arlen[8 +: 8] = 8'd7; req_arid[IDW +: IDW] = 4'd9;
    req_arvalid = 2'b10; req_rready = 2'b10;
    cyc();
    chk("cc_wgnt", 64'(wr_gnt_o), 2'b01);
    chk("cc_rgnt", 64'(rd_gnt_o), 2'b10);
    chk("cc_araddr", 64'(mem_araddr), 64'h9a20_0000);
    chk("cc_arlen", 64'(mem_arlen), 7);
    chk("cc_awlen", 64'(mem_awlen), 7);
    cyc();
    req_awvalid = '0; req_arvalid = '0;
    for (int i = 0; i < 8; i++) begin
      req_wdata[0 +: DW] = 32'h100 + i; req_wlast = (i == 7) ? 2'b01 : 2'b00; req_wvalid = 2'b01;
      mem_rvalid = 1'b1; mem_rdata = 32'h200 + i; mem_rlast = (i == 7); mem_rid = 4'd9;
      #1;
      chk("cc_wdata", 64'(mem_wdata), 64'h100 + i);
      chk("cc_wready", 64'(req_wready), 2'b01);
      chk("cc_rvalid", 64'(req_rvalid), 2'b10);
      chk("cc_rdata", 64'(req_rdata), 64'h200 + i);
      cyc();
    end
    req_wvalid = '0; req_wlast = '0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    chk("cc_rd_done", 64'(rd_gnt_o), 0);
    chk("cc_rid", 64'(req_rid), 9);
    mem_bvalid = 1'b1; mem_bid = 4'd3; req_bready = 2'b01;
    #1;
    chk("cc_bvalid", 64'(req_bvalid), 2'b01);
    chk("cc_bid", 64'(req_bid), 3);
    cyc();
    mem_bvalid = 1'b0;
    chk("cc_wr_done", 64'(wr_gnt_o), 0);
    // requester 1 pushes W beats without owning the write path
    req_awlen[0 +: 8] = 8'd1; req_awvalid = 2'b01;
    req_wdata[DW +: DW] = 32'hBAD; req_wvalid = 2'b10; req_wlast = 2'b10;
    cyc();
    chk("ho_gnt", 64'(wr_gnt_o), 2'b01);
    chk("ho_wready_addr", 64'(req_wready), 0);
    cyc();
    req_awvalid = '0;
    for (int i = 0; i < 2; i++) begin
      req_wdata[0 +: DW] = 32'h300 + i; req_wvalid = 2'b11; req_wlast = (i == 1) ? 2'b11 : 2'b10;
      #1;
      chk("ho_wready", 64'(req_wready), 2'b01);
      chk("ho_wdata", 64'(mem_wdata), 64'h300 + i);
      cyc();
    end
    req_wvalid = 2'b10;
    #1;
    chk("ho_wready_resp", 64'(req_wready), 0);
    chk("ho_wvalid_resp", 64'(mem_wvalid), 0);
    mem_bvalid = 1'b1;
    cyc();
    mem_bvalid = 1'b0; req_wvalid = '0; req_wlast = '0;
    chk("ho_done", 64'(wr_gnt_o), 0);
    chk("pre_to_err", 64'(err_o), 0);
    // response timeout
    req_awlen[0 +: 8] = 8'd0; req_awvalid = 2'b01;
    cyc(2);
    req_awvalid = '0; req_wvalid = 2'b01; req_wlast = 2'b01; req_wdata[0 +: DW] = 32'h55;
    cyc();
    req_wvalid = '0; req_wlast = '0;
    cyc(10);
    chk("to_early", 64'(err_o), 0);
    cyc(10);
    chk("to_set", 64'(err_o), 1);
    mem_bvalid = 1'b1;
    #1 chk("to_late_b", 64'(req_bvalid), 2'b01);
    cyc();
    mem_bvalid = 1'b0;
    chk("to_sticky", 64'(err_o), 1);
    chk("to_done", 64'(wr_gnt_o), 0);
    // reset in the middle of an 8-beat read
    req_arlen[8 +: 8] = 8'd7; req_arvalid = 2'b10; req_rready = 2'b10;
    mem_rvalid = 1'b1; mem_rlast = 1'b0;
    cyc();
    chk("rs_gnt", 64'(rd_gnt_o), 2'b10);
    cyc();
    req_arvalid = '0;
    cyc(2);
    chk("rs_beat2", 64'(req_rvalid), 2'b10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rs_gnt_clr", 64'(rd_gnt_o), 0);
    chk("rs_arvalid", 64'(mem_arvalid), 0);
    chk("rs_rvalid", 64'(req_rvalid), 0);
    chk("rs_err_clr", 64'(err_o), 0);
    mem_rvalid = 1'b0;
    req_arvalid = 2'b11;
    cyc();
    chk("rs_fresh", 64'(rd_gnt_o), 2'b01);
    chk("rs_fresh_ar", 64'(mem_arvalid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
